// File: rtl/spfifo_rw_scheduler.sv
// spfifo_rw_scheduler
// Front-end for a single-port FIFO driven by {WE,RE,DI} instruction words.
// Independent write and read requests are serialised into at most one FIFO
// operation per cycle. On a conflict, the prio side wins and prio then flips.
// Occupancy tracking blocks overflow and underflow. Returned FIFO data is
// forwarded to the requester in order.
// Optional build macro: SPFIFO_SCHED_STATS_EN adds a saturating
// conflict_cnt[15:0] output.
module spfifo_rw_scheduler #(
  parameter int DW      = 32,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [DW-1:0]    wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [DW-1:0]    rd_data,
  output logic             rd_data_valid,
  output logic [DW+1:0]    inst,
  input  logic [DW-1:0]    fifo_res,
  input  logic             fifo_read_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef SPFIFO_SCHED_STATS_EN
  ,
  output logic [15:0]      conflict_cnt
`endif
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  prio_e            prio_q, prio_d;
  logic [DW+1:0]    inst_q, inst_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             rd_data_valid_q, rd_data_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] out_q, out_d;

  logic we_ok;
  logic re_ok;
  logic conflict;
  logic ret_ok;

  // Eligibility, arbitration grants and occupancy flags
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    we_ok    = wr_valid & ~full;
    re_ok    = rd_req & ~empty & (out_q < OUT_W'(MAX_OUT));
    conflict = we_ok & re_ok;
    wr_ready = we_ok & (~re_ok | (prio_q == PRIO_WR));
    rd_ack   = re_ok & (~we_ok | (prio_q == PRIO_RD));
    // Returns with nothing in flight are spurious and dropped.
    ret_ok   = fifo_read_valid & (out_q != '0);
  end

  // Next-state: instruction word, occupancy, in-flight reads, prio, return path
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    prio_d          = prio_q;
    inst_d          = '0;
    count_d         = count_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = ret_ok;
    if (conflict) begin
      prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end
    if (wr_ready) begin
      inst_d  = {2'b10, wr_data};
      count_d = count_q + CNT_W'(1);
    end else if (rd_ack) begin
      inst_d  = {2'b01, {DW{1'b0}}};
      count_d = count_q - CNT_W'(1);
    end
    // A new read grant and a return in the same cycle cancel out.
    out_d = out_q + OUT_W'(rd_ack) - OUT_W'(ret_ok);
    if (ret_ok) begin
      rd_data_d = fifo_res;
    end
  end

  // State registers; reset discards any reads still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q          <= PRIO_WR;
      inst_q          <= '0;
      count_q         <= '0;
      out_q           <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      prio_q          <= prio_d;
      inst_q          <= inst_d;
      count_q         <= count_d;
      out_q           <= out_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

  assign inst          = inst_q;
  assign count         = count_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;

`ifdef SPFIFO_SCHED_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating count of cycles where both sides were eligible
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Conflict counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  // Without statistics, arbitration is unchanged and no counter exists.
`endif

endmodule

// File: tb/tb_spfifo_rw_scheduler.sv
// tb_spfifo_rw_scheduler
// Self-checking bench for spfifo_rw_scheduler. It includes a simple
// single-port FIFO that executes the issued instructions and returns read
// data with a random latency. It also keeps a request-level reference model:
// occupancy, reads in flight, conflict priority and the expected read-data
// order. Define SPFIFO_SCHED_STATS_EN to also check conflict_cnt.
module tb_spfifo_rw_scheduler;

  localparam int DW      = 32;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int MAX_OUT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_valid;
  logic [DW-1:0]    wr_data;
  logic             wr_ready;
  logic             rd_req;
  logic             rd_ack;
  logic [DW-1:0]    rd_data;
  logic             rd_data_valid;
  logic [DW+1:0]    inst;
  logic [DW-1:0]    fifo_res;
  logic             fifo_read_valid;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
`ifdef SPFIFO_SCHED_STATS_EN
  logic [15:0]      conflict_cnt;
`endif

  spfifo_rw_scheduler #(
    .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT)
  ) dut (
`ifdef SPFIFO_SCHED_STATS_EN
    .conflict_cnt   (conflict_cnt),
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .rd_req         (rd_req),
    .rd_ack         (rd_ack),
    .rd_data        (rd_data),
    .rd_data_valid  (rd_data_valid),
    .inst           (inst),
    .fifo_res       (fifo_res),
    .fifo_read_valid(fifo_read_valid),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  int            m_count;
  int            m_out;
  bit            m_prio_rd;
  int            m_conf;
  logic [DW-1:0] exp_q[$];

  // Attached FIFO model and its return pipe
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend_data[$];
  int            pend_due[$];
  bit            stall;
  int            max_delay;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_count   = 0;
    m_out     = 0;
    m_prio_rd = 1'b0;
    m_conf    = 0;
    exp_q.delete();
    fq.delete();
    pend_data.delete();
    pend_due.delete();
  endtask

  task automatic check_reset_state();
    check("rst_inst",  inst, '0);
    check("rst_count", count, '0);
    check("rst_empty", empty, 1'b1);
    check("rst_full",  full, 1'b0);
    check("rst_rdv",   rd_data_valid, 1'b0);
    check("rst_rdata", rd_data, '0);
`ifdef SPFIFO_SCHED_STATS_EN
    check("rst_conf",  conflict_cnt, '0);
`endif
  endtask

  // Asynchronous reset asserted between edges; state must clear immediately
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    wr_valid        = 1'b0;
    rd_req          = 1'b0;
    fifo_read_valid = 1'b0;
    stall           = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle, entered and left at a falling edge
  task automatic step(output bit g_wr, output bit g_rd);
    bit            we_ok, re_ok, frv, exp_rdv;
    logic [DW+1:0] exp_inst;
    logic [DW-1:0] d;
    frv = 1'b0;
    fifo_res = '0;
    if (!stall && pend_data.size() > 0 && pend_due[0] <= cyc) begin
      frv = 1'b1;
      fifo_res = pend_data.pop_front();
      void'(pend_due.pop_front());
    end else if (pend_data.size() == 0 && m_out == 0 && $urandom_range(0, 5) == 0) begin
      frv = 1'b1;
      fifo_res = $urandom;
    end
    fifo_read_valid = frv;
    #1;
    we_ok = wr_valid && (m_count != DEPTH);
    re_ok = rd_req && (m_count != 0) && (m_out < MAX_OUT);
    g_wr  = we_ok && (!re_ok || !m_prio_rd);
    g_rd  = re_ok && (!we_ok || m_prio_rd);
    check("wr_ready", wr_ready, g_wr);
    check("rd_ack",   rd_ack, g_rd);
    check("no_we_re", inst[DW+1] & inst[DW], 1'b0);
    // The FIFO executes the instruction currently on inst at the next edge
    if (inst[DW+1]) fq.push_back(inst[DW-1:0]);
    if (inst[DW]) begin
      d = '0;
      if (fq.size() > 0) d = fq.pop_front();
      pend_data.push_back(d);
      pend_due.push_back(cyc + 1 + int'($urandom_range(0, max_delay)));
    end
    @(posedge clk);
    #1;
    exp_rdv = frv && (m_out > 0);
    exp_inst = '0;
    if (g_wr) begin
      m_count++;
      exp_q.push_back(wr_data);
      exp_inst = {2'b10, wr_data};
    end
    if (g_rd) begin
      m_count--;
      m_out++;
      exp_inst = {2'b01, {DW{1'b0}}};
    end
    if (exp_rdv) m_out--;
    if (we_ok && re_ok) begin
      m_prio_rd = !m_prio_rd;
      if (m_conf < 16'hFFFF) m_conf++;
    end
    check("inst",  inst, exp_inst);
    check("count", count, m_count);
    check("full",  full, m_count == DEPTH);
    check("empty", empty, m_count == 0);
    check("rd_data_valid", rd_data_valid, exp_rdv);
    if (exp_rdv) begin
      if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
      else check("rd_data_extra", 1'b1, 1'b0);
    end
`ifdef SPFIFO_SCHED_STATS_EN
    check("conflict_cnt", conflict_cnt, m_conf);
`endif
    cyc++;
    @(negedge clk);
  endtask

  // Read until the model shows nothing stored or in flight, bounded
  task automatic drain(input int budget);
    bit gw, gr;
    rd_req = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (m_count == 0) rd_req = 1'b0;
      if (m_count == 0 && m_out == 0 && pend_data.size() == 0) break;
      step(gw, gr);
    end
    rd_req = 1'b0;
    check("drain_done", m_out + m_count, 0);
  endtask

  initial begin
    bit gw, gr;
    int acks;
    rst_n           = 1'b0;
    wr_valid        = 1'b0;
    wr_data         = '0;
    rd_req          = 1'b0;
    fifo_res        = '0;
    fifo_read_valid = 1'b0;
    stall           = 1'b0;
    max_delay       = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    // Fill with 1..9: eight accepted, ninth held at full
    wr_valid = 1'b1;
    for (int v = 1; v <= 9; v++) begin
      wr_data = DW'(v);
      for (int k = 0; k < 3; k++) begin
        step(gw, gr);
        if (gw) break;
      end
    end
    check("fill_full", full, 1'b1);
    check("fill_count", count, DEPTH);
    wr_valid = 1'b0;

    // Drain with rd_req held: 1..8 back in order, further requests not acked
    rd_req = 1'b1;
    acks = 0;
    for (int k = 0; k < 40 && acks < 8; k++) begin
      step(gw, gr);
      if (gr) acks++;
    end
    check("drain_acks", acks, 8);
    for (int k = 0; k < 4; k++) step(gw, gr);
    check("drain_empty", empty, 1'b1);
    check("drain_q", exp_q.size(), 0);
    rd_req = 1'b0;

    // Write 1,2 then continuous conflicting requests: grants alternate
    wr_valid = 1'b1;
    for (int v = 1; v <= 2; v++) begin
      wr_data = DW'(v);
      step(gw, gr);
    end
    wr_data = 32'd100;
    rd_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(gw, gr);
      if (gw) wr_data = wr_data + 1;
    end
    wr_valid = 1'b0;
    drain(60);

    // Returns stalled with reads pending: no third ack until one returns
    max_delay = 1;
    wr_valid = 1'b1;
    for (int v = 0; v < 4; v++) begin
      wr_data = $urandom;
      step(gw, gr);
    end
    wr_valid = 1'b0;
    stall = 1'b1;
    rd_req = 1'b1;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      step(gw, gr);
      if (gr) acks++;
    end
    check("stall_acks", acks, MAX_OUT);
    stall = 1'b0;
    drain(60);

    // Randomised traffic with a mid-run reset
    max_delay = 3;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        do_reset();
        wr_valid = 1'b1;
        wr_data  = $urandom;
      end
      if (!wr_valid && $urandom_range(0, 2) != 0) begin
        wr_valid = 1'b1;
        wr_data  = $urandom;
      end
      if (!rd_req && $urandom_range(0, 2) != 0) rd_req = 1'b1;
      if ($urandom_range(0, 15) == 0) stall = !stall;
      step(gw, gr);
      if (gw) wr_valid = 1'b0;
      if (gr) rd_req = 1'b0;
    end
    stall = 1'b0;
    wr_valid = 1'b0;
    drain(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
